// File: rtl/axis_pkt_fifo.sv
// axis_pkt_fifo: AXI-Stream FIFO with TLAST, store-and-forward mode, thresholds, counters and flush
module axis_pkt_fifo #(
  parameter int TDATA_WIDTH       = 128,
  parameter int FIFO_DEPTH        = 256,
  parameter bit PACKET_MODE       = 0,
  parameter int PROG_FULL_THRESH  = FIFO_DEPTH - 8,
  parameter int PROG_EMPTY_THRESH = 8
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   flush,
  input  logic [TDATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic                   S_AXIS_TLAST,
  input  logic                   S_AXIS_TVALID,
  output logic                   S_AXIS_TREADY,
  output logic [TDATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                   M_AXIS_TLAST,
  output logic                   M_AXIS_TVALID,
  input  logic                   M_AXIS_TREADY,
  output logic [31:0]            data_count,
  output logic [31:0]            pkt_count,
  output logic                   prog_full,
  output logic                   prog_empty,
  output logic                   oversize
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);
  logic [TDATA_WIDTH:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wptr, r_rptr;
  logic [CW-1:0]          r_cnt, r_pkt, r_pend, r_avail, r_rel_d;
  logic                   r_trdy, r_ovld, r_olast, r_ovr, r_oversize, r_pf, r_pe;
  logic [TDATA_WIDTH-1:0] r_odata;
  logic                   w_wr, w_rd, w_load, w_last, w_ovf;
  logic [CW-1:0]          w_cnt_n, w_pkt_n, w_rel, w_pend_n;
  // r_pend: written words not yet covered by a TLAST; r_rel_d delays their release one cycle
  always_comb begin
    w_wr     = S_AXIS_TVALID & r_trdy & ~flush;
    w_rd     = r_ovld & M_AXIS_TREADY & ~flush;
    w_load   = (r_avail != '0) & (~r_ovld | M_AXIS_TREADY) & ~flush;
    w_last   = w_wr & S_AXIS_TLAST;
    w_ovf    = PACKET_MODE & ~r_ovr & (r_cnt == DEPTH) & (r_pkt == '0);
    w_cnt_n  = flush ? '0 : r_cnt + CW'(w_wr) - CW'(w_rd);
    w_pkt_n  = flush ? '0 : r_pkt + CW'(w_last) - CW'(w_rd & r_olast);
    w_rel    = w_ovf ? r_pend : (!PACKET_MODE || r_ovr) ? CW'(w_wr) : w_last ? r_pend + CW'(1) : '0;
    w_pend_n = (!PACKET_MODE || w_ovf || r_ovr || w_last) ? '0 : r_pend + CW'(w_wr);
  end
  always_ff @(posedge aclk)
    if (w_wr) r_mem[r_wptr] <= {S_AXIS_TLAST, S_AXIS_TDATA};
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_cnt      <= '0;
      r_pkt      <= '0;
      r_pend     <= '0;
      r_avail    <= '0;
      r_rel_d    <= '0;
      r_trdy     <= 1'b0;
      r_ovld     <= 1'b0;
      r_olast    <= 1'b0;
      r_odata    <= '0;
      r_ovr      <= 1'b0;
      r_oversize <= 1'b0;
      r_pf       <= 1'b0;
      r_pe       <= 1'b1;
    end else begin
      r_cnt  <= w_cnt_n;
      r_pkt  <= w_pkt_n;
      r_trdy <= w_cnt_n < DEPTH;
      r_pf   <= 32'(w_cnt_n) >= 32'(PROG_FULL_THRESH);
      r_pe   <= 32'(w_cnt_n) <= 32'(PROG_EMPTY_THRESH);
      if (flush) begin
        r_wptr     <= '0;
        r_rptr     <= '0;
        r_pend     <= '0;
        r_avail    <= '0;
        r_rel_d    <= '0;
        r_ovld     <= 1'b0;
        r_olast    <= 1'b0;
        r_odata    <= '0;
        r_ovr      <= 1'b0;
        r_oversize <= 1'b0;
      end else begin
        r_wptr  <= r_wptr + AW'(w_wr);
        r_rptr  <= r_rptr + AW'(w_load);
        r_pend  <= w_pend_n;
        r_rel_d <= w_rel;
        r_avail <= r_avail + r_rel_d - CW'(w_load);
        if (w_load) begin
          {r_olast, r_odata} <= r_mem[r_rptr];
          r_ovld             <= 1'b1;
        end else if (w_rd) r_ovld <= 1'b0;
        // an oversize packet streams cut-through until its own TLAST is written
        if (w_ovf) begin
          r_ovr      <= 1'b1;
          r_oversize <= 1'b1;
        end else if (r_ovr & w_last) r_ovr <= 1'b0;
      end
    end
  assign S_AXIS_TREADY = r_trdy;
  assign M_AXIS_TDATA  = r_odata;
  assign M_AXIS_TLAST  = r_olast;
  assign M_AXIS_TVALID = r_ovld;
  assign data_count    = 32'(r_cnt);
  assign pkt_count     = 32'(r_pkt);
  assign prog_full     = r_pf;
  assign prog_empty    = r_pe;
  assign oversize      = r_oversize;
endmodule
